fu_arbiter: RTL and testbench

FU_ARBITER -- requirements
Module: fu_arbiter

---
 rtl/fu_pkg.sv | 45 ++++
 rtl/FunctionUnit.sv | 52 +++++
 rtl/fu_arbiter.sv | 94 +++++++++
 tb/tb_fu_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_pkg.sv
// Shared definitions for the function-unit arbiter slice.
// Holds the FS opcode encodings, the FS legality check, the arbitration
// mode encodings and the packed result payload carried from the
// FunctionUnit into the output register.
package fu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FS_W    = 4;
  localparam int unsigned SHAMT_W = 5;

  // Arbitration modes for fu_arbiter.PRIO_MODE
  localparam int unsigned PRIO_RR    = 0;
  localparam int unsigned PRIO_FIXED = 1;

  // FunctionUnit operation selects
  localparam logic [FS_W-1:0] FS_ADD  = 4'b0000;
  localparam logic [FS_W-1:0] FS_SUB  = 4'b1000;
  localparam logic [FS_W-1:0] FS_SLT  = 4'b0010;
  localparam logic [FS_W-1:0] FS_SLTU = 4'b0011;
  localparam logic [FS_W-1:0] FS_AND  = 4'b0111;
  localparam logic [FS_W-1:0] FS_OR   = 4'b0110;
  localparam logic [FS_W-1:0] FS_XOR  = 4'b0100;
  localparam logic [FS_W-1:0] FS_SLL  = 4'b0001;
  localparam logic [FS_W-1:0] FS_SRL  = 4'b0101;
  localparam logic [FS_W-1:0] FS_SRA  = 4'b1101;

  // Result payload: value plus flags plus illegal-op marker
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              z;
    logic              c;
    logic              v;
    logic              err;
  } fu_res_t;

  // True for the ten implemented operation selects
  function automatic logic fs_legal(input logic [FS_W-1:0] fs);
    case (fs)
      FS_ADD, FS_SUB, FS_SLT, FS_SLTU, FS_AND,
      FS_OR, FS_XOR, FS_SLL, FS_SRL, FS_SRA: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/FunctionUnit.sv
// Combinational 32-bit function unit.
// Ports: a, b   - operands
//        fs     - operation select (see fu_pkg)
//        res_c  - result, Z/C/V flags and illegal-op flag (combinational)
// Shift amount comes from b[4:0]; arithmetic wraps modulo 2^32.
// C/V are meaningful for ADD/SUB only (C on SUB means "no borrow").
module FunctionUnit
  import fu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [FS_W-1:0]   fs,
  output fu_res_t           res_c
);

  logic                 is_sub;
  logic [DATA_W-1:0]    b_op;
  logic [DATA_W:0]      sum;
  logic [SHAMT_W-1:0]   shamt;

  // Shared adder: SUB is A + ~B + 1 so the carry-out is the no-borrow flag
  always_comb begin
    is_sub = (fs == FS_SUB);
    b_op   = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_op} + (DATA_W+1)'(is_sub);
    shamt  = b[SHAMT_W-1:0];
  end

  // Operation decode
  always_comb begin
    res_c = '0;
    case (fs)
      FS_ADD, FS_SUB: begin
        res_c.result = sum[DATA_W-1:0];
        res_c.c      = sum[DATA_W];
        res_c.v      = (a[DATA_W-1] == b_op[DATA_W-1]) &&
                       (sum[DATA_W-1] != a[DATA_W-1]);
      end
      FS_SLT:  res_c.result = DATA_W'($signed(a) < $signed(b));
      FS_SLTU: res_c.result = DATA_W'(a < b);
      FS_AND:  res_c.result = a & b;
      FS_OR:   res_c.result = a | b;
      FS_XOR:  res_c.result = a ^ b;
      FS_SLL:  res_c.result = a << shamt;
      FS_SRL:  res_c.result = a >> shamt;
      FS_SRA:  res_c.result = DATA_W'($signed(a) >>> shamt);
      default: res_c.err    = 1'b1;
    endcase
    res_c.z = ~res_c.err && (res_c.result == '0);
  end

endmodule

// File: rtl/fu_arbiter.sv
// Two-port arbiter in front of a single FunctionUnit with a one-deep
// registered output stage (latency 1, valid/ready on both sides).
// Ports: clk, rst (async, active-high)
//        r0_*/r1_*  - request ports: valid/ready handshake, a, b, fs
//        out_*      - registered result: valid/ready, id, result, z/c/v, err
// PRIO_MODE: PRIO_RR (alternate on contention) or PRIO_FIXED (port 0 wins).
module fu_arbiter
  import fu_pkg::*;
#(
  parameter int unsigned PRIO_MODE = PRIO_RR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic [3:0]  r0_fs,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic [3:0]  r1_fs,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_id,
  output logic [31:0] out_result,
  output logic        out_z,
  output logic        out_c,
  output logic        out_v,
  output logic        out_err
);

  logic              last_grant;
  logic              rst_hold;   // set by reset, blocks the first edge after release
  logic              grant;
  logic              go;
  logic              accept;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [FS_W-1:0]   sel_fs;
  fu_res_t           fu_res;
  fu_res_t           res_q;

  // Grant selection and ready generation
  always_comb begin
    if (r0_valid && r1_valid)
      grant = (PRIO_MODE == PRIO_FIXED) ? 1'b0 : ~last_grant;
    else
      grant = ~r0_valid;
    go       = ~rst_hold & (~out_valid | out_ready);
    r0_ready = go & r0_valid & ~grant;
    r1_ready = go & r1_valid &  grant;
    accept   = r0_ready | r1_ready;
    sel_a    = grant ? r1_a  : r0_a;
    sel_b    = grant ? r1_b  : r0_b;
    sel_fs   = grant ? r1_fs : r0_fs;
  end

  FunctionUnit u_fu (
    .a     (sel_a),
    .b     (sel_b),
    .fs    (sel_fs),
    .res_c (fu_res)
  );

  // Output stage and arbitration history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_id     <= 1'b0;
      res_q      <= '0;
      last_grant <= 1'b1;
      rst_hold   <= 1'b1;
    end else begin
      rst_hold <= 1'b0;
      if (accept) begin
        out_valid  <= 1'b1;
        out_id     <= grant;
        res_q      <= fu_res;
        last_grant <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_result = res_q.result;
  assign out_z      = res_q.z;
  assign out_c      = res_q.c;
  assign out_v      = res_q.v;
  assign out_err    = res_q.err;

endmodule

// File: tb/tb_fu_arbiter.sv
// Self-checking bench: drives identical stimulus into a round-robin and a
// fixed-priority fu_arbiter, compares both against a reference model every
// negedge, and pins the model with hand-computed literal expectations.
module tb_fu_arbiter;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        v;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r1_valid, out_ready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [3:0]  r0_fs, r1_fs;

  logic        rr0 [2];
  logic        rr1 [2];
  logic        o_valid [2];
  logic        o_id [2];
  logic [31:0] o_res [2];
  logic        o_z [2];
  logic        o_c [2];
  logic        o_v [2];
  logic        o_err [2];

  // reference state per instance (0 = round-robin, 1 = fixed priority)
  logic        m_ov [2];
  logic        m_id [2];
  exp_t        m_out [2];
  logic        m_lg [2];
  logic        m_blk [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fu_arbiter #(.PRIO_MODE(0)) u_rr (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(rr0[0]), .r0_a(r0_a), .r0_b(r0_b), .r0_fs(r0_fs),
    .r1_valid(r1_valid), .r1_ready(rr1[0]), .r1_a(r1_a), .r1_b(r1_b), .r1_fs(r1_fs),
    .out_valid(o_valid[0]), .out_ready(out_ready), .out_id(o_id[0]),
    .out_result(o_res[0]), .out_z(o_z[0]), .out_c(o_c[0]), .out_v(o_v[0]),
    .out_err(o_err[0])
  );

  fu_arbiter #(.PRIO_MODE(1)) u_fix (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(rr0[1]), .r0_a(r0_a), .r0_b(r0_b), .r0_fs(r0_fs),
    .r1_valid(r1_valid), .r1_ready(rr1[1]), .r1_a(r1_a), .r1_b(r1_b), .r1_fs(r1_fs),
    .out_valid(o_valid[1]), .out_ready(out_ready), .out_id(o_id[1]),
    .out_result(o_res[1]), .out_z(o_z[1]), .out_c(o_c[1]), .out_v(o_v[1]),
    .out_err(o_err[1])
  );

  // Operation semantics written directly from the op table
  function automatic exp_t ref_fu(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] fs);
    exp_t e;
    logic [63:0] s;
    int unsigned sh;
    e  = '0;
    sh = 32'(b[4:0]);
    case (fs)
      4'b0000: begin
        s   = 64'(a) + 64'(b);
        e.r = s[31:0];
        e.c = s[32];
        e.v = (a[31] == b[31]) && (e.r[31] != a[31]);
      end
      4'b1000: begin
        e.r = a - b;
        e.c = (a >= b);
        e.v = (a[31] != b[31]) && (e.r[31] != a[31]);
      end
      4'b0010: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: e.r = (a < b) ? 32'd1 : 32'd0;
      4'b0111: e.r = a & b;
      4'b0110: e.r = a | b;
      4'b0100: e.r = a ^ b;
      4'b0001: e.r = a << sh;
      4'b0101: e.r = a >> sh;
      4'b1101: e.r = 32'($signed(a) >>> sh);
      default: e.e = 1'b1;
    endcase
    if (!e.e) e.z = (e.r == 32'd0);
    return e;
  endfunction

  // Which port wins given the valids, instance mode and previous winner
  function automatic logic pick(input int k, input logic v0, input logic v1,
                                input logic lg);
    if (v0 && v1) return (k == 1) ? 1'b0 : !lg;
    return v1 && !v0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model update
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_ov[k]  <= 1'b0;
        m_id[k]  <= 1'b0;
        m_out[k] <= '0;
        m_lg[k]  <= 1'b1;
        m_blk[k] <= 1'b1;
      end else begin
        m_blk[k] <= 1'b0;
        if (!m_blk[k] && (!m_ov[k] || out_ready) && (r0_valid || r1_valid)) begin
          m_ov[k]  <= 1'b1;
          m_id[k]  <= pick(k, r0_valid, r1_valid, m_lg[k]);
          m_lg[k]  <= pick(k, r0_valid, r1_valid, m_lg[k]);
          m_out[k] <= pick(k, r0_valid, r1_valid, m_lg[k]) ? ref_fu(r1_a, r1_b, r1_fs)
                                                           : ref_fu(r0_a, r0_b, r0_fs);
        end else if (out_ready) begin
          m_ov[k] <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic can, g;
      can = !rst && !m_blk[k] && (!m_ov[k] || out_ready);
      g   = pick(k, r0_valid, r1_valid, m_lg[k]);
      chk($sformatf("d%0d.r0_ready", k), 32'(rr0[k]), 32'(can && r0_valid && !g));
      chk($sformatf("d%0d.r1_ready", k), 32'(rr1[k]), 32'(can && r1_valid && g));
      chk($sformatf("d%0d.out_valid", k), 32'(o_valid[k]), 32'(m_ov[k]));
      chk($sformatf("d%0d.out_id", k), 32'(o_id[k]), 32'(m_id[k]));
      chk($sformatf("d%0d.out_result", k), o_res[k], m_out[k].r);
      chk($sformatf("d%0d.flags", k), {28'd0, o_z[k], o_c[k], o_v[k], o_err[k]},
          {28'd0, m_out[k].z, m_out[k].c, m_out[k].v, m_out[k].e});
    end
  end

  logic        exp_ids [4];
  logic [31:0] exp_res [4];

  initial begin
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_res = '{32'd30, 32'd1, 32'd30, 32'd1};
    rst = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0; out_ready = 1'b0;
    r0_a = '0; r0_b = '0; r0_fs = '0; r1_a = '0; r1_b = '0; r1_fs = '0;
    repeat (2) cyc();

    // reset state, readies held low even with both requests present
    r0_valid = 1'b1; r1_valid = 1'b1;
    r0_a = 32'd60; r0_b = 32'd30; r0_fs = 4'b1000;
    r1_a = 32'd30; r1_b = 32'd60; r1_fs = 4'b0011;
    #1;
    chk("rst.out_valid", 32'(o_valid[0]), 32'd0);
    chk("rst.out_result", o_res[0], 32'd0);
    chk("rst.r0_ready", 32'(rr0[0]), 32'd0);
    chk("rst.r1_ready", 32'(rr1[0]), 32'd0);

    // contention: release reset, first edge is not an accept edge
    out_ready = 1'b1;
    rst = 1'b0;
    cyc();
    chk("rel.out_valid", 32'(o_valid[0]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("cont.id%0d", i), 32'(o_id[0]), 32'(exp_ids[i]));
      chk($sformatf("cont.res%0d", i), o_res[0], exp_res[i]);
      if (i < 3) begin
        chk($sformatf("fix.id%0d", i), 32'(o_id[1]), 32'd0);
        chk($sformatf("fix.r1_ready%0d", i), 32'(rr1[1]), 32'd0);
      end
    end

    // single request on r0 (drains previous result at the same edge)
    r1_valid = 1'b0;
    r0_a = 32'd60; r0_b = 32'd30; r0_fs = 4'b0000;
    cyc();
    r0_valid = 1'b0;
    chk("single.valid", 32'(o_valid[0]), 32'd1);
    chk("single.id", 32'(o_id[0]), 32'd0);
    chk("single.res", o_res[0], 32'd90);
    chk("single.z", 32'(o_z[0]), 32'd0);

    // backpressure with r1 waiting
    out_ready = 1'b0;
    r1_valid = 1'b1; r1_a = 32'd5; r1_b = 32'd7; r1_fs = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp.r1_ready%0d", i), 32'(rr1[0]), 32'd0);
      chk($sformatf("bp.res%0d", i), o_res[0], 32'd90);
      chk($sformatf("bp.valid%0d", i), 32'(o_valid[0]), 32'd1);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("bp.r1_go", 32'(rr1[0]), 32'd1);
    cyc();
    r1_valid = 1'b0;
    chk("bp.id", 32'(o_id[0]), 32'd1);
    chk("bp.res", o_res[0], 32'd12);

    // illegal operation
    r0_valid = 1'b1; r0_a = 32'd1; r0_b = 32'd2; r0_fs = 4'b1111;
    #1;
    chk("ill.r0_ready", 32'(rr0[0]), 32'd1);
    cyc();
    r0_valid = 1'b0;
    #1;
    chk("ill.r0_ready_drop", 32'(rr0[0]), 32'd0);
    chk("ill.err", 32'(o_err[0]), 32'd1);
    chk("ill.res", o_res[0], 32'd0);

    // reset while an SRA result is pending
    r0_valid = 1'b1; r0_a = 32'hFFFF_FFC0; r0_b = 32'd2; r0_fs = 4'b1101;
    cyc();
    r0_valid = 1'b0; out_ready = 1'b0;
    chk("sra.res", o_res[0], 32'hFFFF_FFF0);
    chk("sra.valid", 32'(o_valid[0]), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async.valid", 32'(o_valid[0]), 32'd0);
    chk("async.res", o_res[0], 32'd0);
    r0_valid = 1'b1; r1_valid = 1'b1;
    r0_a = 32'd3; r0_b = 32'd4; r0_fs = 4'b0000;
    #1;
    chk("inrst.r0_ready", 32'(rr0[0]), 32'd0);
    chk("inrst.r1_ready", 32'(rr1[0]), 32'd0);
    cyc();
    cyc();
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("rel2.r0_ready", 32'(rr0[0]), 32'd0);
    cyc();
    chk("rel2.valid", 32'(o_valid[0]), 32'd0);
    cyc();
    chk("rel2.id", 32'(o_id[0]), 32'd0);
    chk("rel2.res", o_res[0], 32'd7);
    r0_valid = 1'b0; r1_valid = 1'b0;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
